bcd_adder_arbiter: RTL and testbench
====================================

Name: bcd_adder_arbiter

Overview:
Time-shares one combinational BCD adder core between two requesters. Each requester offers a pair of 4-bit binary operands (0..15) on a valid/ready handshake. A round-robin arbiter grants one request at a time and sequences the adder over a configurable number of cycles. The block then returns a registered two-digit BCD result (tens/units), tagged with the requester ID, on a valid/ready output handshake. It sits between operand sources (key/switch decoders) and the display/result sink.

Parameters:
FIRST_PRIO, 0, requester that wins the first tie after reset (0 or 1)
CALC_CYCLES, 1, cycles spent in CALC before the result is captured (1..8)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has operands
req0_ready  out  1  requester 0 operands accepted this cycle
req0_a  in  4  requester 0 operand A, binary
req0_b  in  4  requester 0 operand B, binary
req1_valid  in  1  requester 1 has operands
req1_ready  out  1  requester 1 operands accepted this cycle
req1_a  in  4  requester 1 operand A
req1_b  in  4  requester 1 operand B
res_valid  out  1  result available
res_ready  in  1  sink accepts result
res_id  out  1  requester that owns the result
res_tens  out  4  BCD tens digit (0..3)
res_units  out  4  BCD units digit (0..9)
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: state=IDLE, res_valid=0, res_id=0, res_tens=0, res_units=0, busy=0, CALC counter=0, last_grant=~FIRST_PRIO. Any in-flight operation is discarded; no result is emitted for it.
- States: IDLE, CALC, HOLD.
- IDLE, grant selection:
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - req_ready is combinational: asserted only for the granted requester, only in IDLE.
  - Accept (valid&&ready): latch a, b and ID; update last_grant=ID; go to CALC.
- CALC:
  - The latched operands drive bcd_add_core.
  - Count CALC_CYCLES cycles.
  - On the last count, register tens/units/ID into the result registers, set res_valid=1 and go to HOLD.
- HOLD:
  - res_valid, res_id, res_tens and res_units are held stable.
  - If res_ready is high, res_valid=0 next cycle and the FSM returns to IDLE.
  - No new accept occurs in HOLD.
- Latency: from accept edge to res_valid high is CALC_CYCLES+1 edges (2 at default). Minimum issue interval is CALC_CYCLES+2 cycles.
- Arithmetic:
  - sum=a+b as 5 bits, range 0..30.
  - tens=sum/10 and units=sum%10, computed with compare-subtract (≥30, ≥20, ≥10). No divider.
- Requester rules:
  - A requester holds valid and operands stable until accepted.
  - Operand changes after accept have no effect on the result.
  - Dropping valid before ready is tolerated: no accept happens, no error.
- Simultaneous events:
  - A valid from the same requester in the cycle after its accept is not served until HOLD completes.
  - A res_ready pulse outside HOLD is ignored.
- Starvation: with both requesters continuously valid, grants strictly alternate.
- Reset in CALC or HOLD: the FSM returns to IDLE on the next edge and res_valid drops immediately at that edge.

Decomposition:
- Package bcd_arb_pkg:
  - State enum (IDLE, CALC, HOLD).
  - Requester ID constants REQ0=0 and REQ1=1.
  - BCD digit width constant DIGIT_W=4.
  - Max operand sum constant 30.
- Sub-module bcd_add_core: purely combinational. Inputs are 4-bit a and b; outputs are 4-bit tens and units. It is instantiated once inside bcd_adder_arbiter.

Test Plan:
1. Reset, then req0 a=11 b=9 with res_ready=1 → req0_ready pulses one cycle; 2 cycles later res_valid=1, res_id=0, tens=2, units=0.
2. req1 a=15 b=15, then req0 a=8 b=9 → results in order: (id=1, tens=3, units=0), then (id=0, tens=1, units=7).
3. Both valid continuously for 4 operations, FIRST_PRIO=0 → grant order 0,1,0,1.
4. res_ready low for 5 cycles during HOLD → res_valid and digits are stable for all 5 cycles; req_ready stays 0; release → next accept follows in IDLE.
5. Assert rst for one cycle during CALC (a=15, b=15) → no res_valid ever rises for that operation; all outputs are 0; a fresh request afterwards completes normally.
6. CALC_CYCLES=4, a=0 b=0 → res_valid rises 5 edges after accept with tens=0, units=0; busy is high from the accept edge until res accepted.

Source files
------------

// File: rtl/bcd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_arb_pkg
// Brief  : Shared constants for the time-shared BCD adder and its arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package bcd_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DIGIT_W = 4;
    localparam int MAX_SUM = 30;

endpackage
`default_nettype wire

// File: rtl/bcd_add_core.sv
`default_nettype none
// ============================================================================
// Module : bcd_add_core
// Brief  : Combinational 4-bit + 4-bit binary add, split into BCD tens/units.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_add_core
    import bcd_arb_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] units_o
);

    logic [4:0] w_sum;

    assign w_sum = {1'b0, a_i} + {1'b0, b_i};

    // The remainder is always below 10, so subtracting on the low nibble
    // modulo 16 gives the exact units digit.
    always_comb begin
        tens_o  = 4'd0;
        units_o = w_sum[3:0];
        if (w_sum >= 5'(MAX_SUM)) begin
            tens_o  = 4'd3;
            units_o = w_sum[3:0] - 4'(MAX_SUM);
        end else if (w_sum >= 5'd20) begin
            tens_o  = 4'd2;
            units_o = w_sum[3:0] - 4'(20);
        end else if (w_sum >= 5'd10) begin
            tens_o  = 4'd1;
            units_o = w_sum[3:0] - 4'd10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bcd_adder_arbiter
// Brief  : Round-robin arbiter sharing one BCD adder core between two requesters.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_adder_arbiter
    import bcd_arb_pkg::*;
#(
    parameter logic FIRST_PRIO  = 1'b0,
    parameter int   CALC_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [DIGIT_W-1:0] req0_a_i,
    input  logic [DIGIT_W-1:0] req0_b_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [DIGIT_W-1:0] req1_a_i,
    input  logic [DIGIT_W-1:0] req1_b_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               res_id_o,
    output logic [DIGIT_W-1:0] res_tens_o,
    output logic [DIGIT_W-1:0] res_units_o,
    output logic               busy_o
);

    localparam logic [2:0] c_cnt_last = 3'(CALC_CYCLES - 1);

    logic [1:0]         state_q,      state_d;
    logic [2:0]         cnt_q,        cnt_d;
    logic               last_grant_q, last_grant_d;
    logic [DIGIT_W-1:0] a_q,          a_d;
    logic [DIGIT_W-1:0] b_q,          b_d;
    logic               id_q,         id_d;
    logic               res_valid_q,  res_valid_d;
    logic               res_id_q,     res_id_d;
    logic [DIGIT_W-1:0] tens_q,       tens_d;
    logic [DIGIT_W-1:0] units_q,      units_d;

    logic               w_idle;
    logic               w_grant;
    logic               w_ready0;
    logic               w_ready1;
    logic [DIGIT_W-1:0] w_tens;
    logic [DIGIT_W-1:0] w_units;

    bcd_add_core u_core (
        .a_i     (a_q),
        .b_i     (b_q),
        .tens_o  (w_tens),
        .units_o (w_units)
    );

    // On a tie the requester not served last wins, which forces alternation.
    assign w_idle   = (state_q == ST_IDLE);
    assign w_grant  = (req0_valid_i && req1_valid_i) ? ~last_grant_q :
                      (req1_valid_i ? REQ1 : REQ0);
    assign w_ready0 = w_idle && req0_valid_i && (w_grant == REQ0);
    assign w_ready1 = w_idle && req1_valid_i && (w_grant == REQ1);

    assign req0_ready_o = w_ready0;
    assign req1_ready_o = w_ready1;
    assign res_valid_o  = res_valid_q;
    assign res_id_o     = res_id_q;
    assign res_tens_o   = tens_q;
    assign res_units_o  = units_q;
    assign busy_o       = ~w_idle;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        tens_d       = tens_q;
        units_d      = units_q;
        case (state_q)
            ST_IDLE: begin
                if (w_ready0 || w_ready1) begin
                    a_d          = w_grant ? req1_a_i : req0_a_i;
                    b_d          = w_grant ? req1_b_i : req0_b_i;
                    id_d         = w_grant;
                    last_grant_d = w_grant;
                    cnt_d        = 3'd0;
                    state_d      = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == c_cnt_last) begin
                    tens_d      = w_tens;
                    units_d     = w_units;
                    res_id_d    = id_q;
                    res_valid_d = 1'b1;
                    cnt_d       = 3'd0;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HOLD: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= ~FIRST_PRIO;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            tens_q       <= '0;
            units_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_adder_arbiter
// Brief  : Directed, table-driven self-checking bench for bcd_adder_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bcd_adder_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0_valid, req1_valid, res_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready, res_valid, res_id, busy;
    logic [3:0] res_tens, res_units;

    logic       q4_valid, q4_ready, z_valid, z_ready, res4_ready, res4_valid, res4_id, busy4;
    logic [3:0] q4_a, q4_b, z_a, z_b, res4_tens, res4_units;

    bcd_adder_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
        .res_tens_o(res_tens), .res_units_o(res_units), .busy_o(busy)
    );

    bcd_adder_arbiter #(.CALC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid_i(q4_valid), .req0_ready_o(q4_ready), .req0_a_i(q4_a), .req0_b_i(q4_b),
        .req1_valid_i(z_valid), .req1_ready_o(z_ready), .req1_a_i(z_a), .req1_b_i(z_b),
        .res_valid_o(res4_valid), .res_ready_i(res4_ready), .res_id_o(res4_id),
        .res_tens_o(res4_tens), .res_units_o(res4_units), .busy_o(busy4)
    );

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] tens;
        logic [3:0] units;
    } vec_t;

    vec_t tbl [10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One complete transaction on the default-parameter DUT with res_ready held high.
    task automatic run_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] et, input logic [3:0] eu, input string nm);
        int   n;
        logic got;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        n   = 0;
        got = id ? req1_ready : req0_ready;
        while (!got && n < 20) begin
            @(negedge clk); #1; n++;
            got = id ? req1_ready : req0_ready;
        end
        chk({nm, " accept"}, 8'(got), 8'd1);
        chk({nm, " other_ready"}, 8'(id ? req0_ready : req1_ready), 8'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        #1;
        chk({nm, " ready_pulse"}, 8'(id ? req1_ready : req0_ready), 8'd0);
        chk({nm, " busy_calc"}, 8'(busy), 8'd1);
        n = 1;
        while (!res_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({nm, " latency"}, 8'(n), 8'd2);
        chk({nm, " id"}, 8'(res_id), 8'(id));
        chk({nm, " tens"}, 8'(res_tens), 8'(et));
        chk({nm, " units"}, 8'(res_units), 8'(eu));
        @(negedge clk); #1;
        chk({nm, " valid_drop"}, 8'(res_valid), 8'd0);
        chk({nm, " busy_idle"}, 8'(busy), 8'd0);
    endtask

    task automatic wait_res(input string nm);
        int n;
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({nm, " res_timeout"}, 8'(res_valid), 8'd1);
    endtask

    initial begin
        int   n;
        logic flag;

        tbl[0] = '{1'b0, 4'd11, 4'd9,  4'd2, 4'd0};
        tbl[1] = '{1'b1, 4'd15, 4'd15, 4'd3, 4'd0};
        tbl[2] = '{1'b0, 4'd8,  4'd9,  4'd1, 4'd7};
        tbl[3] = '{1'b1, 4'd0,  4'd0,  4'd0, 4'd0};
        tbl[4] = '{1'b0, 4'd9,  4'd0,  4'd0, 4'd9};
        tbl[5] = '{1'b1, 4'd5,  4'd5,  4'd1, 4'd0};
        tbl[6] = '{1'b0, 4'd10, 4'd9,  4'd1, 4'd9};
        tbl[7] = '{1'b1, 4'd15, 4'd5,  4'd2, 4'd0};
        tbl[8] = '{1'b0, 4'd14, 4'd15, 4'd2, 4'd9};
        tbl[9] = '{1'b1, 4'd7,  4'd2,  4'd0, 4'd9};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        q4_valid = 1'b0; q4_a = '0; q4_b = '0; res4_ready = 1'b1;
        z_valid = 1'b0; z_a = '0; z_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst res_valid", 8'(res_valid), 8'd0);
        chk("rst res_id",    8'(res_id),    8'd0);
        chk("rst tens",      8'(res_tens),  8'd0);
        chk("rst units",     8'(res_units), 8'd0);
        chk("rst busy",      8'(busy),      8'd0);
        chk("rst ready0",    8'(req0_ready), 8'd0);
        chk("rst ready1",    8'(req1_ready), 8'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].tens, tbl[i].units,
                   $sformatf("vec%0d", i));
        end

        // Round-robin with both requesters continuously valid, starting from reset.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd3;  req0_b = 4'd4;
        req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd13;
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk); #1; n++;
            end
            chk($sformatf("rr%0d grant", k), 8'(req1_ready), 8'(k % 2));
            chk($sformatf("rr%0d single", k), 8'(req0_ready & req1_ready), 8'd0);
            wait_res($sformatf("rr%0d", k));
            chk($sformatf("rr%0d id", k), 8'(res_id), 8'(k % 2));
            chk($sformatf("rr%0d tens", k), 8'(res_tens), (k % 2) ? 8'd2 : 8'd0);
            chk($sformatf("rr%0d units", k), 8'(res_units), (k % 2) ? 8'd5 : 8'd7);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Back-pressure: result must hold while res_ready stays low.
        @(negedge clk);
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("hold accept", 8'(req0_ready), 8'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
        #1;
        wait_res("hold");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d valid", i), 8'(res_valid), 8'd1);
            chk($sformatf("hold%0d id", i), 8'(res_id), 8'd0);
            chk($sformatf("hold%0d tens", i), 8'(res_tens), 8'd1);
            chk($sformatf("hold%0d units", i), 8'(res_units), 8'd3);
            chk($sformatf("hold%0d ready1", i), 8'(req1_ready), 8'd0);
            @(negedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk); #1;
        chk("hold release valid", 8'(res_valid), 8'd0);
        chk("hold release ready1", 8'(req1_ready), 8'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        wait_res("after_hold");
        chk("after_hold id", 8'(res_id), 8'd1);
        chk("after_hold tens", 8'(res_tens), 8'd0);
        chk("after_hold units", 8'(res_units), 8'd4);
        @(negedge clk);

        // Reset while in CALC discards the operation.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("rstcalc accept", 8'(req0_ready), 8'd1);
        @(negedge clk);
        req0_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rstcalc busy", 8'(busy), 8'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstcalc valid", 8'(res_valid), 8'd0);
        chk("rstcalc id",    8'(res_id),    8'd0);
        chk("rstcalc tens",  8'(res_tens),  8'd0);
        chk("rstcalc units", 8'(res_units), 8'd0);
        chk("rstcalc busy0", 8'(busy),      8'd0);
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            flag = flag | res_valid;
        end
        chk("rstcalc no_result", 8'(flag), 8'd0);
        run_op(1'b1, 4'd4, 4'd3, 4'd0, 4'd7, "post_rst");

        // Longer CALC phase on the second instance.
        @(negedge clk);
        q4_valid = 1'b1; q4_a = 4'd0; q4_b = 4'd0;
        #1;
        n = 0;
        while (!q4_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("cc4 accept", 8'(q4_ready), 8'd1);
        @(negedge clk);
        q4_valid = 1'b0; q4_a = 4'd15; q4_b = 4'd15;
        #1;
        n = 1;
        flag = 1'b1;
        while (!res4_valid && n < 30) begin
            flag = flag & busy4;
            @(negedge clk); #1; n++;
        end
        chk("cc4 latency", 8'(n), 8'd5);
        chk("cc4 busy_calc", 8'(flag), 8'd1);
        chk("cc4 busy_hold", 8'(busy4), 8'd1);
        chk("cc4 tens", 8'(res4_tens), 8'd0);
        chk("cc4 units", 8'(res4_units), 8'd0);
        chk("cc4 id", 8'(res4_id), 8'd0);
        @(negedge clk); #1;
        chk("cc4 valid_drop", 8'(res4_valid), 8'd0);
        chk("cc4 busy_idle", 8'(busy4), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
